mc_ctrl_unit: RTL

Multi-cycle control unit for the RV32I-subset core. It replaces the single-cycle combinational decoder with a registered FSM. The FSM fetches an instruction through a valid handshake, latches it in an internal instruction register, and sequences decode, execute, memory and writeback. It drives the datapath's enables, selects, the sign-extended immediate and a sticky illegal-instruction flag. The unit sits between instruction memory, data memory and the register-file/ALU datapath.

---
 rtl/mc_ctrl_unit_pkg.sv | 43 ++++
 rtl/mc_ctrl_unit_if.sv | 46 ++++
 rtl/mc_ctrl_unit_imm_ext.sv | 29 ++
 rtl/mc_ctrl_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_unit_pkg.sv
// Shared types for the multi-cycle control unit: FSM states, opcodes, ALU ops, immediate formats.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } ctrl_state_t;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2,
        IMM_B    = 2'd3
    } imm_fmt_t;

    // Immediate layout implied by the opcode; R-type and unknown opcodes carry none.
    function automatic imm_fmt_t imm_fmt(input logic [6:0] opcode);
        case (opcode)
            OP_IMM, LOAD: return IMM_I;
            STORE:        return IMM_S;
            BRANCH:       return IMM_B;
            default:      return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_unit_if.sv
// Bus between the control unit and imem/dmem/datapath; retired exists only with CTRL_PERF_EN.
// Latency: n/a (wiring only).
// Backpressure: instr_valid stalls FETCH, mem_ready stalls MEM.
interface mc_ctrl_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic [DATA_WIDTH-1:0] instr;
    logic                  instr_valid;
    logic                  mem_ready;
    logic                  eq;
    logic                  ir_en;
    logic                  pc_en;
    logic                  PCsrc;
    logic                  RegWrite;
    logic [2:0]            ALUctrl;
    logic                  ALUsrc;
    logic [DATA_WIDTH-1:0] ImmOp;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  ResultSrc;
    logic                  illegal;
    logic                  busy;
`ifdef CTRL_PERF_EN
    logic [CNT_WIDTH-1:0]  retired;
`endif

    modport ctrl (
        input  instr, instr_valid, mem_ready, eq,
        output ir_en, pc_en, PCsrc, RegWrite, ALUctrl, ALUsrc, ImmOp,
               MemRead, MemWrite, ResultSrc, illegal, busy
`ifdef CTRL_PERF_EN
        , output retired
`endif
    );

    modport dp (
        output instr, instr_valid, mem_ready, eq,
        input  ir_en, pc_en, PCsrc, RegWrite, ALUctrl, ALUsrc, ImmOp,
               MemRead, MemWrite, ResultSrc, illegal, busy
`ifdef CTRL_PERF_EN
        , input retired
`endif
    );

endinterface

// File: rtl/mc_ctrl_unit_imm_ext.sv
// Builds the sign-extended byte-offset immediate from the instruction register.
// Latency: combinational.
// Backpressure: none.
module imm_ext
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] ir,
    input  imm_fmt_t              fmt,
    output logic [DATA_WIDTH-1:0] imm
);

    // Opcode, rs1 and funct3 fields never contribute to an immediate.
    logic unused_bits;
    assign unused_bits = ^{ir[19:12], ir[6:0]};

    // Reassemble the scattered fields and replicate ir[31] as the sign.
    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
            IMM_S:   imm = {{(DATA_WIDTH-12){ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle RV32I-subset control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP); CTRL_PERF_EN adds a retire counter.
// Latency: branch 3, ALU 4, sw 4, lw 5 cycles minimum; outputs combinational from state and IR.
// Backpressure: holds in FETCH until instr_valid, holds in MEM until mem_ready; TRAP holds until reset.
module mc_ctrl_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic         clk,
    input  logic         rst,
    mc_ctrl_unit_if.ctrl bus
);
    import ctrl_pkg::*;

    if (CNT_WIDTH < 1 || DATA_WIDTH < 32) begin : g_bad_param
        $error("mc_ctrl_unit: CNT_WIDTH must be >= 1 and DATA_WIDTH >= 32");
    end

    ctrl_state_t           state;
    ctrl_state_t           state_nxt;
    logic [DATA_WIDTH-1:0] ir;
    logic                  ir_en;
    logic                  pc_en;
    logic                  legal;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_op;
    logic       is_load;
    logic       is_store;
    logic       is_branch;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    assign is_op     = (opcode == OP);
    assign is_load   = (opcode == LOAD);
    assign is_store  = (opcode == STORE);
    assign is_branch = (opcode == BRANCH);

    imm_ext #(.DATA_WIDTH(DATA_WIDTH)) u_imm_ext (
        .ir  (ir),
        .fmt (imm_fmt(opcode)),
        .imm (bus.ImmOp)
    );

    // Only the exact funct3/funct7 encodings of the supported instructions are legal.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_IMM:       legal = (funct3 == 3'b000);
            OP:           legal = (funct3 == 3'b000) &&
                                  ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
            LOAD, STORE:  legal = (funct3 == 3'b010);
            BRANCH:       legal = (funct3[2:1] == 2'b00);
            default:      legal = 1'b0;
        endcase
    end

    // State sequencing; instr_valid and mem_ready are only looked at in their own states.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  if (bus.instr_valid) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = legal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                if (is_branch)                state_nxt = ST_FETCH;
                else if (is_load || is_store) state_nxt = ST_MEM;
                else                          state_nxt = ST_WB;
            end
            ST_MEM:    if (bus.mem_ready) state_nxt = is_load ? ST_WB : ST_FETCH;
            ST_WB:     state_nxt = ST_FETCH;
            ST_TRAP:   state_nxt = ST_TRAP;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    // State and instruction register; IR loads only on an accepted fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FETCH;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (ir_en) ir <= bus.instr;
        end
    end

    // Datapath controls decoded from state and IR; eq is consulted only for branches in EXEC.
    always_comb begin
        ir_en         = 1'b0;
        pc_en         = 1'b0;
        bus.PCsrc     = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ALUctrl   = ALU_ADD;
        bus.ALUsrc    = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.ResultSrc = 1'b0;
        case (state)
            // Gating with rst keeps ir_en low while reset is asserted.
            ST_FETCH: ir_en = bus.instr_valid & rst;
            ST_EXEC: begin
                if (is_branch) begin
                    bus.ALUctrl = ALU_SUB;
                    pc_en       = 1'b1;
                    bus.PCsrc   = funct3[0] ? ~bus.eq : bus.eq;
                end else if (is_op) begin
                    bus.ALUctrl = funct7[5] ? ALU_SUB : ALU_ADD;
                end else begin
                    bus.ALUsrc  = 1'b1;
                end
            end
            ST_MEM: begin
                bus.MemRead  = is_load;
                bus.MemWrite = is_store;
                pc_en        = is_store & bus.mem_ready;
            end
            ST_WB: begin
                bus.RegWrite  = 1'b1;
                pc_en         = 1'b1;
                bus.ResultSrc = is_load;
            end
            default: ;
        endcase
    end

    assign bus.ir_en   = ir_en;
    assign bus.pc_en   = pc_en;
    assign bus.busy    = (state != ST_FETCH);
    assign bus.illegal = (state == ST_TRAP);

`ifdef CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] retired_q;

    // One retire per pc_en pulse; wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) retired_q <= '0;
        else if (pc_en) retired_q <= retired_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    assign bus.retired = retired_q;
`endif

endmodule
